mux_nx1_scan: RTL and testbench
===============================

# mux_nx1_scan

Registered N-input, WIDTH-bit multiplexer. It extends the combinational 4:1 mux family with a configurable channel count, an output valid/ready handshake and an optional auto-scan mode. In auto-scan mode the block rotates through the channels, emitting DWELL samples per channel. It sits between parallel sample sources and a single downstream consumer that may stall.

## Interface
- WIDTH, 16, data width per channel (≥1)
- N, 4, number of input channels (≥2, need not be a power of two)
- DWELL, 4, accepted samples per channel before scan advances (≥1)
- SEL_W, $clog2(N), select/channel index width (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- din  in  N*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  manual channel select
- mode  in  1  0 = manual, 1 = auto-scan (scan build only)
- en  in  1  sample enable
- o_data  out  WIDTH  registered selected sample
- o_chan  out  SEL_W  channel index that produced o_data
- o_valid  out  1  o_data/o_chan valid
- o_ready  in  1  downstream accepts when o_valid && o_ready
- o_err  out  1  registered flag: current sample came from an out-of-range sel

## Operation
- Load condition: load = en && (!o_valid || o_ready). On load the block registers the sample, the index and the error flag, and sets o_valid.
- When !load && o_ready, o_valid clears.
- When o_valid && !o_ready, o_data, o_chan and o_err hold stable. Stable outputs under stall are mandatory.
- Channel source: in MAN the channel is sel. In SCAN the channel is the pointer ptr.
- Out-of-range select (sel ≥ N, only possible when N is not a power of two): o_data = 0, o_chan = sel, o_err = 1.
- FSM states MAN and SCAN:
  - MAN→SCAN when mode=1 at a clock edge. ptr loads sel, or 0 if sel ≥ N. cnt clears.
  - SCAN→MAN when mode=0. The next load uses sel.
- SCAN counting: cnt counts accepted transfers (o_valid && o_ready) of the current ptr. At cnt == DWELL-1 plus a transfer:
  - cnt goes to 0.
  - ptr goes to ptr+1, wrapping from N-1 to 0.
- If a transfer and a mode change occur in the same cycle, the mode change wins. cnt clears and ptr reloads as above.
- Only accepted samples count toward DWELL. Stalled or disabled cycles never advance ptr.

## Timing
- Latency: 1 cycle from din/sel to o_data.
- A new sample can be loaded in the same cycle the previous one is accepted, so throughput is 1 sample/cycle.
- Reset values: o_data = 0, o_chan = 0, o_valid = 0, o_err = 0, state = MAN, ptr = 0, cnt = 0.
- Reset mid-stall discards the held sample. o_valid is 0 on the cycle after rst.
- en = 0 while o_valid && o_ready: o_valid drops next cycle.
- en = 0 while stalled: the sample holds.
- A ptr advance takes effect on the next load. The sample loaded in the same cycle as the DWELL-th transfer already comes from the new ptr.

## Configuration
- Macro: MUX_NX1_SCAN_EN.
- Defined: full behaviour as described above (FSM, ptr, cnt, DWELL).
- Undefined:
  - The mode input is ignored.
  - No FSM, ptr or cnt registers are built; the block behaves permanently as MAN.
  - DWELL is unused.

## Structure
- Package mux_pkg holds:
  - the state enum (MAN, SCAN);
  - the mode constants MODE_MAN = 0 and MODE_SCAN = 1.
- Sub-module scan_ctr (present only under MUX_NX1_SCAN_EN):
  - contains ptr and cnt;
  - inputs: advance strobe, reload strobe, reload value;
  - parameters: N, DWELL.
- The top level contains the select mux, out-of-range detection and the output handshake register.

## Test plan
- Manual, N = 4, WIDTH = 16, din = {0x0400, 0x8000, 0x0001, 0x0180}, o_ready = 1, en = 1, sel stepped 0..3 → o_data = 0x0180, 0x0001, 0x8000, 0x0400 one cycle after each sel, with o_chan matching.
- Stall: o_ready = 0 for 5 cycles with sel and din changing → o_data, o_chan and o_valid constant. Release → held sample accepted, then new samples follow back-to-back.
- Scan, N = 4, DWELL = 4, o_ready = 1, en = 1 → o_chan sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. With o_ready toggling 1/0, each channel still yields exactly 4 accepted samples.
- Out-of-range, N = 3, WIDTH = 8, sel = 3 → o_data = 0x00, o_err = 1, o_chan = 3. sel = 2 → o_err = 0.
- Reset mid-scan (ptr = 2, o_valid = 1, o_ready = 0), assert rst one cycle → all outputs 0, state MAN. With the macro undefined, mode = 1 has no effect.

Source files
------------

// File: rtl/mux_nx1_scan_pkg.sv
// Shared types for the registered N:1 scan multiplexer.
// Holds the control state enum and the mode input encodings.
package mux_pkg;

  typedef enum logic {
    MAN  = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Sample-side bus of mux_nx1_scan: parallel inputs, selection controls and
// the registered output with its valid/ready handshake.
interface mux_nx1_scan_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] din;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic               en;
  logic [WIDTH-1:0]   o_data;
  logic [SEL_W-1:0]   o_chan;
  logic               o_valid;
  logic               o_ready;
  logic               o_err;

  modport master (
    output din, sel, mode, en, o_ready,
    input  o_data, o_chan, o_valid, o_err
  );

  modport slave (
    input  din, sel, mode, en, o_ready,
    output o_data, o_chan, o_valid, o_err
  );

endinterface

// File: rtl/mux_nx1_scan_ctr.sv
// Auto-scan channel pointer and per-channel dwell counter.
// ptr_adv is the pointer a load in this cycle must use (already advanced on the DWELL-th transfer).
module scan_ctr #(
  parameter  int N     = 4,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             reload,
  input  logic [SEL_W-1:0] reload_val,
  output logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] ptr_adv
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last    = (cnt_q == CNT_LAST);
  assign ptr_inc = (ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + SEL_W'(1);
  assign ptr_adv = (advance && last) ? ptr_inc : ptr_q;
  assign ptr     = ptr_q;

  // A reload (mode change) overrides a coincident transfer.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (reload) begin
      ptr_d = reload_val;
      cnt_d = '0;
    end else if (advance) begin
      if (last) begin
        cnt_d = '0;
        ptr_d = ptr_inc;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux with valid/ready output and optional auto-scan.
// Auto-scan (MAN/SCAN FSM, scan_ctr) is built only when MUX_NX1_SCAN_EN is defined.
//
// state | meaning
// MAN   | channel taken from sel
// SCAN  | channel taken from the rotating scan pointer
module mux_nx1_scan
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_nx1_scan_if.slave  bus
);

  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             xfer, load, sel_oor, src_oor;
  logic [SEL_W-1:0] src_chan;
  logic [WIDTH-1:0] mux_data;

  assign xfer    = valid_q && bus.o_ready;
  assign load    = bus.en && (!valid_q || bus.o_ready);
  assign sel_oor = {1'b0, bus.sel} >= (SEL_W + 1)'(N);

`ifdef MUX_NX1_SCAN_EN
  state_e           state_q, state_d;
  logic             reload, advance;
  logic [SEL_W-1:0] ptr, ptr_adv, reload_val;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAN:     if (bus.mode == MODE_SCAN) state_d = SCAN;
      SCAN:    if (bus.mode == MODE_MAN)  state_d = MAN;
      default: state_d = MAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MAN;
    else     state_q <= state_d;
  end

  assign reload     = (state_d != state_q);
  assign reload_val = sel_oor ? '0 : bus.sel;
  assign advance    = (state_q == SCAN) && xfer && !reload;
  assign src_chan   = (state_q == SCAN) ? ptr_adv : bus.sel;
  assign src_oor    = (state_q == SCAN) ? 1'b0 : sel_oor;

  scan_ctr #(.N(N), .DWELL(DWELL)) u_scan_ctr (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .reload     (reload),
    .reload_val (reload_val),
    .ptr        (ptr),
    .ptr_adv    (ptr_adv)
  );
`else
  localparam int unused_dwell = DWELL;
  logic          unused_mode;

  assign unused_mode = bus.mode;
  assign src_chan    = bus.sel;
  assign src_oor     = sel_oor;
`endif

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (src_chan == SEL_W'(k)) mux_data = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // Outputs only change on a load, so they stay frozen while stalled.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = src_oor ? '0 : mux_data;
      chan_d  = src_chan;
      err_d   = src_oor;
      valid_d = 1'b1;
    end else if (bus.o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_chan  = chan_q;
  assign bus.o_valid = valid_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: a 4x16 instance (DWELL 4) and a 3x8 instance (DWELL 2)
// checked every cycle against a transfer-counting reference model.
module tb_mux_nx1_scan;

  localparam int DW_A = 4;
  localparam int DW_B = 2;
  localparam logic [63:0] DIN_A = 64'h0400_8000_0001_0180;
  localparam logic [23:0] DIN_B = 24'h33_22_11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_nx1_scan_if #(.WIDTH(16), .N(4)) bus_a ();
  mux_nx1_scan_if #(.WIDTH(8),  .N(3)) bus_b ();

  mux_nx1_scan #(.WIDTH(16), .N(4), .DWELL(DW_A)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_nx1_scan #(.WIDTH(8),  .N(3), .DWELL(DW_B)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: in scan the channel is base + (transfers since scan entry) / DWELL, modulo N.
  typedef struct {
    bit valid;
    int data;
    int chan;
    bit err;
    bit scan;
    int base;
    int acc;
  } mdl_t;

  mdl_t m_a, m_b;
  int   acc_q[$];

  function automatic mdl_t mdl_step(mdl_t m, int n, int dwell, int width, logic [63:0] din,
                                    int sel, bit mode, bit en, bit rdy, bit rst_i);
    mdl_t r = m;
    bit   xfer, load, oor;
    int   acc_incl, ch;
    if (rst_i) begin
      r = '{valid: 0, data: 0, chan: 0, err: 0, scan: 0, base: 0, acc: 0};
      return r;
    end
    xfer     = m.valid && rdy;
    load     = en && (!m.valid || rdy);
    acc_incl = m.acc + (xfer ? 1 : 0);
    if (load) begin
      if (m.scan) begin
        ch  = (m.base + acc_incl / dwell) % n;
        oor = 1'b0;
      end else begin
        ch  = sel;
        oor = (sel >= n);
      end
      r.chan  = ch;
      r.err   = oor;
      r.data  = oor ? 0 : int'((din >> (ch * width)) & ((64'd1 << width) - 64'd1));
      r.valid = 1'b1;
    end else if (rdy) begin
      r.valid = 1'b0;
    end
`ifdef MUX_NX1_SCAN_EN
    if (mode != m.scan) begin
      r.scan = mode;
      r.acc  = 0;
      r.base = (sel >= n) ? 0 : sel;
    end else if (m.scan) begin
      r.acc = acc_incl;
    end
`else
    if (mode) r.scan = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    m_a = mdl_step(m_a, 4, DW_A, 16, bus_a.din, int'(bus_a.sel), bus_a.mode, bus_a.en,
                   bus_a.o_ready, rst);
    m_b = mdl_step(m_b, 3, DW_B, 8, {40'd0, bus_b.din}, int'(bus_b.sel), bus_b.mode, bus_b.en,
                   bus_b.o_ready, rst);
    if (!rst && bus_a.o_valid && bus_a.o_ready) acc_q.push_back(int'(bus_a.o_chan));
    @(posedge clk);
    #1;
    chk("a_valid", {31'd0, bus_a.o_valid}, m_a.valid);
    chk("a_data",  {16'd0, bus_a.o_data},  m_a.data);
    chk("a_chan",  {30'd0, bus_a.o_chan},  m_a.chan);
    chk("a_err",   {31'd0, bus_a.o_err},   m_a.err);
    chk("b_valid", {31'd0, bus_b.o_valid}, m_b.valid);
    chk("b_data",  {24'd0, bus_b.o_data},  m_b.data);
    chk("b_chan",  {30'd0, bus_b.o_chan},  m_b.chan);
    chk("b_err",   {31'd0, bus_b.o_err},   m_b.err);
  endtask

  typedef struct {
    logic [1:0]  sel;
    bit          en;
    bit          rdy;
    logic [15:0] data;
    logic [1:0]  chan;
    bit          valid;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'd0, 1'b1, 1'b1, 16'h0180, 2'd0, 1'b1};
    vecs[1]  = '{2'd1, 1'b1, 1'b1, 16'h0001, 2'd1, 1'b1};
    vecs[2]  = '{2'd2, 1'b1, 1'b1, 16'h8000, 2'd2, 1'b1};
    vecs[3]  = '{2'd3, 1'b1, 1'b1, 16'h0400, 2'd3, 1'b1};
    vecs[4]  = '{2'd0, 1'b0, 1'b1, 16'h0400, 2'd3, 1'b0};
    vecs[5]  = '{2'd1, 1'b1, 1'b0, 16'h0001, 2'd1, 1'b1};
    vecs[6]  = '{2'd2, 1'b1, 1'b0, 16'h0001, 2'd1, 1'b1};
    vecs[7]  = '{2'd2, 1'b1, 1'b1, 16'h8000, 2'd2, 1'b1};
    vecs[8]  = '{2'd3, 1'b0, 1'b0, 16'h8000, 2'd2, 1'b1};
    vecs[9]  = '{2'd3, 1'b0, 1'b1, 16'h8000, 2'd2, 1'b0};
    vecs[10] = '{2'd0, 1'b1, 1'b0, 16'h0180, 2'd0, 1'b1};
    vecs[11] = '{2'd3, 1'b1, 1'b1, 16'h0400, 2'd3, 1'b1};

    rst = 1'b1;
    bus_a.din = DIN_A; bus_a.sel = '0; bus_a.mode = 1'b0; bus_a.en = 1'b0; bus_a.o_ready = 1'b1;
    bus_b.din = DIN_B; bus_b.sel = '0; bus_b.mode = 1'b0; bus_b.en = 1'b0; bus_b.o_ready = 1'b1;
    tick();
    chk("rst_valid", {31'd0, bus_a.o_valid}, 0);
    chk("rst_data",  {16'd0, bus_a.o_data},  0);
    chk("rst_chan",  {30'd0, bus_a.o_chan},  0);
    chk("rst_err",   {31'd0, bus_a.o_err},   0);
    rst = 1'b0;

    // Manual-select vectors
    for (int i = 0; i < 12; i++) begin
      bus_a.sel = vecs[i].sel; bus_a.en = vecs[i].en; bus_a.o_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_data", i),  {16'd0, bus_a.o_data},  {16'd0, vecs[i].data});
      chk($sformatf("vec%0d_chan", i),  {30'd0, bus_a.o_chan},  {30'd0, vecs[i].chan});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus_a.o_valid}, {31'd0, vecs[i].valid});
    end

    // Five-cycle stall with changing inputs, then back-to-back release
    bus_a.o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_a.sel = 2'($urandom_range(0, 3));
      bus_a.din = {$urandom, $urandom};
      tick();
      chk("stall_data",  {16'd0, bus_a.o_data},  32'h0400);
      chk("stall_chan",  {30'd0, bus_a.o_chan},  3);
      chk("stall_valid", {31'd0, bus_a.o_valid}, 1);
    end
    bus_a.din = DIN_A; bus_a.o_ready = 1'b1; bus_a.sel = 2'd1;
    tick();
    chk("rel_data0", {16'd0, bus_a.o_data}, 32'h0001);
    bus_a.sel = 2'd2;
    tick();
    chk("rel_data1", {16'd0, bus_a.o_data}, 32'h8000);
    bus_a.sel = 2'd0;
    tick();
    chk("rel_data2", {16'd0, bus_a.o_data}, 32'h0180);

    // Out-of-range select on the 3-channel instance
    bus_b.en = 1'b1; bus_b.o_ready = 1'b1; bus_b.sel = 2'd3;
    tick();
    chk("oor_data", {24'd0, bus_b.o_data}, 0);
    chk("oor_err",  {31'd0, bus_b.o_err},  1);
    chk("oor_chan", {30'd0, bus_b.o_chan}, 3);
    bus_b.sel = 2'd2;
    tick();
    chk("inr_data", {24'd0, bus_b.o_data}, 32'h33);
    chk("inr_err",  {31'd0, bus_b.o_err},  0);

    // Random manual traffic
    for (int i = 0; i < 200; i++) begin
      bus_a.din = {$urandom, $urandom}; bus_a.sel = 2'($urandom_range(0, 3));
      bus_a.en = ($urandom_range(0, 3) != 0); bus_a.o_ready = ($urandom_range(0, 2) != 0);
      bus_b.din = 24'($urandom); bus_b.sel = 2'($urandom_range(0, 3));
      bus_b.en = ($urandom_range(0, 3) != 0); bus_b.o_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    bus_a.din = DIN_A; bus_b.din = DIN_B;
    bus_a.en = 1'b0; bus_a.o_ready = 1'b1; bus_b.en = 1'b0; bus_b.o_ready = 1'b1;
    tick(); tick();

`ifdef MUX_NX1_SCAN_EN
    // Continuous scan from channel 0
    bus_a.mode = 1'b1; bus_a.sel = 2'd0;
    tick();
    bus_a.en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("scan_seq%0d", i), {30'd0, bus_a.o_chan}, (i / 4) % 4);
    end

    // Scan from channel 1 with o_ready toggling: accepted samples stay grouped by 4
    bus_a.en = 1'b0; bus_a.mode = 1'b0;
    tick(); tick();
    bus_a.mode = 1'b1; bus_a.sel = 2'd1;
    tick();
    acc_q.delete();
    bus_a.en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus_a.o_ready = (i % 2 == 0);
      tick();
    end
    chk("acc_count_ge24", {31'd0, acc_q.size() >= 24}, 1);
    for (int i = 0; i < 24 && i < acc_q.size(); i++)
      chk($sformatf("acc_chan%0d", i), acc_q[i], (1 + i / 4) % 4);

    // Random traffic with mode changes only on disabled cycles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus_a.en = 1'b0; bus_a.mode = ~bus_a.mode;
      end else begin
        bus_a.en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 15) == 0) begin
        bus_b.en = 1'b0; bus_b.mode = ~bus_b.mode;
      end else begin
        bus_b.en = ($urandom_range(0, 3) != 0);
      end
      bus_a.din = {$urandom, $urandom}; bus_a.sel = 2'($urandom_range(0, 3));
      bus_a.o_ready = ($urandom_range(0, 2) != 0);
      bus_b.din = 24'($urandom); bus_b.sel = 2'($urandom_range(0, 3));
      bus_b.o_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset while stalled mid-scan on channel 2
    bus_a.din = DIN_A; bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.o_ready = 1'b1;
    bus_b.en = 1'b0; bus_b.mode = 1'b0;
    tick(); tick();
    bus_a.mode = 1'b1; bus_a.sel = 2'd0;
    tick();
    bus_a.en = 1'b1;
    begin
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        tick();
        if (bus_a.o_valid && bus_a.o_chan == 2'd2) found = 1'b1;
      end
      chk("reach_ptr2", {31'd0, found}, 1);
    end
    bus_a.o_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", {31'd0, bus_a.o_valid}, 0);
    chk("mrst_data",  {16'd0, bus_a.o_data},  0);
    chk("mrst_chan",  {30'd0, bus_a.o_chan},  0);
    chk("mrst_err",   {31'd0, bus_a.o_err},   0);
    bus_a.sel = 2'd3; bus_a.o_ready = 1'b1;
    tick();
    chk("post_rst_man_chan", {30'd0, bus_a.o_chan}, 3);
    chk("post_rst_man_data", {16'd0, bus_a.o_data}, 32'h0400);
`else
    // Without the scan build, mode=1 leaves the block in manual selection
    bus_a.mode = 1'b1; bus_a.sel = 2'd2; bus_a.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("noscan_chan%0d", i), {30'd0, bus_a.o_chan}, 2);
    end
    bus_a.o_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", {31'd0, bus_a.o_valid}, 0);
    chk("mrst_data",  {16'd0, bus_a.o_data},  0);
    bus_a.sel = 2'd1; bus_a.o_ready = 1'b1;
    tick();
    chk("post_rst_chan", {30'd0, bus_a.o_chan}, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
